// File: rtl/dffrl_pipe_if.sv
// Bundle of scan, control and data signals for the dffrl_pipe delay line.
// master drives the inputs of the pipeline; slave is the pipeline itself.
interface dffrl_pipe_if #(
  parameter int unsigned SIZE  = 1,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                    se;
  logic [SIZE-1:0]         si;
  logic [SIZE-1:0]         so;
  logic                    clr;
  logic                    en;
  logic                    vld_in;
  logic [SIZE-1:0]         din;
  logic [SIZE-1:0]         q;
  logic                    vld_out;
  logic [OCC_W-1:0]        occ;
  logic [DEPTH*SIZE-1:0]   stage_q;

  modport master (
    output se, si, clr, en, vld_in, din,
    input  so, q, vld_out, occ, stage_q
  );

  modport slave (
    input  se, si, clr, en, vld_in, din,
    output so, q, vld_out, occ, stage_q
  );
endinterface

// File: rtl/dffrl_pipe.sv
// DEPTH-stage, SIZE-wide scannable delay line with per-stage valid bits,
// advance enable, synchronous clear and an occupancy counter.
// Edge priority: se > clr > en > hold; rst_l low resets asynchronously.
module dffrl_pipe #(
  parameter int unsigned     SIZE    = 1,
  parameter int unsigned     DEPTH   = 2,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          rst_l,
  dffrl_pipe_if.slave  bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Stage i lives in data[i]; the packed layout matches stage_q directly.
  logic [DEPTH-1:0][SIZE-1:0] data;
  logic [DEPTH-1:0]           vld;
  logic [OCC_W-1:0]           occ_r;

  // One-stage-extended views: the new stage-0 value sits at index 0, so the
  // next state of the whole line is simply the low DEPTH entries. This keeps
  // the shift expression legal for DEPTH=1 without a special case.
  logic [DEPTH:0][SIZE-1:0]   scan_chain;
  logic [DEPTH:0][SIZE-1:0]   adv_chain;
  logic [DEPTH:0]             vld_chain;

  assign scan_chain = {data, bus.si};
  assign adv_chain  = {data, bus.din};
  assign vld_chain  = {vld, bus.vld_in};

  // Pipeline state update with scan > clear > advance > hold priority.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      data  <= {DEPTH{RST_VAL}};
      vld   <= '0;
      occ_r <= '0;
    end else if (bus.se) begin
      data  <= scan_chain[DEPTH-1:0];
    end else if (bus.clr) begin
      data  <= {DEPTH{RST_VAL}};
      vld   <= '0;
      occ_r <= '0;
    end else if (bus.en) begin
      data  <= adv_chain[DEPTH-1:0];
      vld   <= vld_chain[DEPTH-1:0];
      occ_r <= occ_r + OCC_W'(bus.vld_in) - OCC_W'(vld[DEPTH-1]);
    end
  end

  assign bus.q       = data[DEPTH-1];
  assign bus.so      = data[DEPTH-1];
  assign bus.vld_out = vld[DEPTH-1];
  assign bus.occ     = occ_r;
  assign bus.stage_q = data;

endmodule

// File: tb/tb_dffrl_pipe.sv
// Self-checking bench for dffrl_pipe (SIZE=8, DEPTH=4, RST_VAL=8'hA5).
// A scoreboard queue tracks every valid word in flight and how many advance
// edges it has seen; a word is expected on q once it has seen DEPTH of them.
module tb_dffrl_pipe;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RV    = 8'hA5;

  logic clk;
  logic rst_l;

  dffrl_pipe_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  dffrl_pipe #(.SIZE(SIZE), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } ent_t;

  ent_t sb[$];
  int   total;
  int   bad;

  task automatic sb_adv(input logic v, input logic [7:0] d);
    for (int i = 0; i < sb.size(); i++) sb[i].pos++;
    while (sb.size() > 0 && sb[0].pos > int'(DEPTH)) void'(sb.pop_front());
    if (v) sb.push_back('{d: d, pos: 1});
  endtask

  function automatic logic [2:0] sb_occ();
    return 3'(sb.size());
  endfunction

  function automatic logic sb_vout();
    return (sb.size() > 0) && (sb[0].pos == int'(DEPTH));
  endfunction

  // One clock: drive at the falling edge, sample 1ns after the rising edge.
  task automatic cyc(input logic s, input logic c, input logic e, input logic v,
                     input logic [7:0] d, input logic [7:0] sin);
    @(negedge clk);
    bus.se = s; bus.clr = c; bus.en = e; bus.vld_in = v; bus.din = d; bus.si = sin;
    @(posedge clk);
    #1;
    if (!s) begin
      if (c) sb.delete();
      else if (e) sb_adv(v, d);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    total++;
    if (bus.q !== RV || bus.so !== RV) begin
      bad++; $display("FAIL rst_q: q=%h so=%h want %h", bus.q, bus.so, RV);
    end
    total++;
    if (bus.vld_out !== 1'b0 || bus.occ !== 3'd0) begin
      bad++; $display("FAIL rst_vld: vld_out=%b occ=%0d want 0/0", bus.vld_out, bus.occ);
    end
    @(negedge clk);
    rst_l = 1'b1;
    sb.delete();
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 8'h3C, 8'h00);
      total++;
      if (bus.stage_q !== {4{RV}} || bus.occ !== 3'd0 || bus.vld_out !== 1'b0) begin
        bad++; $display("FAIL rst_idle%0d: stage_q=%h occ=%0d vld_out=%b want %h/0/0",
                        k, bus.stage_q, bus.occ, bus.vld_out, {4{RV}});
      end
    end
  endtask

  task automatic test_latency();
    cyc(0, 0, 1, 1, 8'h11, 8'h00);
    cyc(0, 0, 1, 1, 8'h22, 8'h00);
    cyc(0, 0, 1, 1, 8'h33, 8'h00);
    total++;
    if (bus.occ !== 3'd3) begin
      bad++; $display("FAIL lat_occ3: occ=%0d want 3", bus.occ);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 8'hFF, 8'h00);
      total++;
      if (bus.vld_out !== 1'b0 || bus.occ !== 3'd3) begin
        bad++; $display("FAIL lat_stall%0d: vld_out=%b occ=%0d want 0/3", k, bus.vld_out, bus.occ);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 8'hEE, 8'h00);
      total++;
      if (bus.occ !== sb_occ() || bus.vld_out !== sb_vout()) begin
        bad++; $display("FAIL lat_drain%0d: occ=%0d vld_out=%b want %0d/%b",
                        k, bus.occ, bus.vld_out, sb_occ(), sb_vout());
      end
      if (sb_vout()) begin
        total++;
        if (bus.q !== sb[0].d) begin
          bad++; $display("FAIL lat_q%0d: q=%h want %h", k, bus.q, sb[0].d);
        end
      end
    end
    total++;
    if (bus.occ !== 3'd0) begin
      bad++; $display("FAIL lat_empty: occ=%0d want 0", bus.occ);
    end
  endtask

  task automatic test_bubbles();
    logic [4:0] pat;
    int         exp_occ [5];
    pat     = 5'b01101;
    exp_occ = '{1, 1, 2, 3, 2};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, pat[k], 8'(8'h40 + k), 8'h00);
      total++;
      if (bus.occ !== 3'(exp_occ[k]) || bus.vld_out !== sb_vout()) begin
        bad++; $display("FAIL bub%0d: occ=%0d vld_out=%b want %0d/%b",
                        k, bus.occ, bus.vld_out, exp_occ[k], sb_vout());
      end
    end
  endtask

  task automatic test_priority();
    cyc(1, 1, 0, 0, 8'h00, 8'h77);
    total++;
    if (bus.occ !== 3'd2 || bus.stage_q[7:0] !== 8'h77 || bus.stage_q[15:8] !== 8'h44) begin
      bad++; $display("FAIL pri_scan: occ=%0d s0=%h s1=%h want 2/77/44",
                      bus.occ, bus.stage_q[7:0], bus.stage_q[15:8]);
    end
    cyc(0, 1, 1, 1, 8'hBB, 8'h00);
    total++;
    if (bus.stage_q !== {4{RV}} || bus.occ !== 3'd0 || bus.vld_out !== 1'b0) begin
      bad++; $display("FAIL pri_clr: stage_q=%h occ=%0d vld_out=%b want %h/0/0",
                      bus.stage_q, bus.occ, bus.vld_out, {4{RV}});
    end
  endtask

  task automatic test_scan();
    cyc(0, 0, 1, 1, 8'h55, 8'h00);
    cyc(1, 0, 0, 0, 8'h00, 8'h01);
    cyc(1, 1, 1, 1, 8'h9A, 8'h02);
    cyc(1, 0, 1, 0, 8'h9B, 8'h03);
    total++;
    if (bus.so !== 8'h55) begin
      bad++; $display("FAIL scan_so3: so=%h want 55", bus.so);
    end
    cyc(1, 0, 0, 0, 8'h00, 8'h04);
    total++;
    if (bus.stage_q !== {8'h01, 8'h02, 8'h03, 8'h04}) begin
      bad++; $display("FAIL scan_stage: stage_q=%h want 01020304", bus.stage_q);
    end
    total++;
    if (bus.so !== 8'h01 || bus.q !== 8'h01) begin
      bad++; $display("FAIL scan_so: so=%h q=%h want 01", bus.so, bus.q);
    end
    total++;
    if (bus.occ !== 3'd1 || bus.vld_out !== 1'b0) begin
      bad++; $display("FAIL scan_vld: occ=%0d vld_out=%b want 1/0", bus.occ, bus.vld_out);
    end
    cyc(0, 1, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 8'(8'h60 + k), 8'h00);
    total++;
    if (bus.occ !== 3'd4 || bus.vld_out !== 1'b1 || bus.q !== sb[0].d) begin
      bad++; $display("FAIL ar_full: occ=%0d vld_out=%b q=%h want 4/1/%h",
                      bus.occ, bus.vld_out, bus.q, sb[0].d);
    end
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    total++;
    if (bus.stage_q !== {4{RV}} || bus.occ !== 3'd0 || bus.vld_out !== 1'b0) begin
      bad++; $display("FAIL ar_now: stage_q=%h occ=%0d vld_out=%b want %h/0/0",
                      bus.stage_q, bus.occ, bus.vld_out, {4{RV}});
    end
    #4 rst_l = 1'b1;
    sb.delete();
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, (k == 1), (k == 1) ? 8'h99 : 8'h00, 8'h00);
      total++;
      if (bus.vld_out !== (k == 4) || bus.vld_out !== sb_vout()) begin
        bad++; $display("FAIL ar_lat%0d: vld_out=%b want %b", k, bus.vld_out, (k == 4));
      end
    end
    total++;
    if (bus.q !== 8'h99 || bus.occ !== 3'd1) begin
      bad++; $display("FAIL ar_q: q=%h occ=%0d want 99/1", bus.q, bus.occ);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_l = 1'b1;
    bus.se = 1'b0; bus.clr = 1'b0; bus.en = 1'b0;
    bus.vld_in = 1'b0; bus.din = '0; bus.si = '0;
    test_reset();
    test_latency();
    test_bubbles();
    test_priority();
    test_scan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
